// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation sensor front-end.
// Holds the fault FSM state encoding, the default filter lengths and a
// helper that sizes saturating counters to the smallest width that can
// hold a given terminal count.
package rega_pkg;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    SUSPEITA = 2'd1,
    FALHA    = 2'd2
  } falhaState_t;

  localparam int DEB_CYCLES_DEF   = 16;
  localparam int FALHA_CYCLES_DEF = 64;

  // Bits needed to represent values 0..maxVal.
  function automatic int cntWidth(input int maxVal);
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/filtro_sensores_if.sv
// Sensor bundle between the field wiring / controller and filtro_sensores.
//   Us_raw, Bs_raw, Vs_raw, Adub_raw : raw asynchronous sensor levels
//   Clr_Falha                        : synchronous, level-sensitive fault clear
//   Us, Bs, Vs, Adub                 : filtered sensor levels
//   Us_sobe                          : one-cycle strobe on filtered Us rising
//   Falha                            : sticky reservoir inconsistency fault
// The master side drives the raw levels and the clear request; the slave
// side (the filter) drives the filtered results.
interface filtro_sensores_if;

  logic Us_raw;
  logic Bs_raw;
  logic Vs_raw;
  logic Adub_raw;
  logic Clr_Falha;
  logic Us;
  logic Bs;
  logic Vs;
  logic Adub;
  logic Us_sobe;
  logic Falha;

  modport master (
    output Us_raw, Bs_raw, Vs_raw, Adub_raw, Clr_Falha,
    input  Us, Bs, Vs, Adub, Us_sobe, Falha
  );

  modport slave (
    input  Us_raw, Bs_raw, Vs_raw, Adub_raw, Clr_Falha,
    output Us, Bs, Vs, Adub, Us_sobe, Falha
  );

endinterface

// File: rtl/debounce_canal.sv
// One sensor channel: 2-flop synchronizer followed by a debounce counter.
// Ports:
//   Clk     : system clock
//   Rst     : asynchronous active-low reset
//   rawIn   : raw asynchronous level
//   filtOut : debounced, registered level
// The counter runs while the synchronized level disagrees with filtOut and
// clears on any agreeing cycle, so only an uninterrupted run of DEB_CYCLES
// disagreeing cycles flips the output.
module debounce_canal
  import rega_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic rawIn,
  output logic filtOut
);

  localparam int            CNT_W    = cntWidth(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             syncA;
  logic             syncB;
  logic [CNT_W-1:0] cnt;

  // The toggle fires on the cycle the count would reach DEB_CYCLES, so the
  // counter itself never exceeds DEB_CYCLES-1 and cannot wrap.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      syncA   <= 1'b0;
      syncB   <= 1'b0;
      cnt     <= '0;
      filtOut <= 1'b0;
    end else begin
      syncA <= rawIn;
      syncB <= syncA;
      if (syncB == filtOut) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filtOut <= ~filtOut;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/filtro_sensores.sv
// Sensor filter for the irrigation controller.
// Ports:
//   Clk : system clock (single domain)
//   Rst : asynchronous active-low reset
//   bus : filtro_sensores_if slave (raw inputs, clear, filtered outputs)
// Four debounced channels, a rising-edge strobe on the soil dryness level
// and a fault FSM that flags a reservoir whose high float reads wet while
// the low float reads dry. While the fault is active both reservoir levels
// are forced to 0 so the controller stops demanding irrigation.
module filtro_sensores
  import rega_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int FALHA_CYCLES = FALHA_CYCLES_DEF
) (
  input logic              Clk,
  input logic              Rst,
  filtro_sensores_if.slave bus
);

  localparam int            FCNT_W    = cntWidth(FALHA_CYCLES);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FALHA_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

  logic usFilt;
  logic bsFilt;
  logic vsFilt;
  logic adubFilt;
  logic usDly;
  logic usSobe;
  logic inconsistent;
  logic falhaReg;

  falhaState_t       state;
  falhaState_t       nextState;
  logic [FCNT_W-1:0] falhaCnt;
  logic [FCNT_W-1:0] falhaCntNext;

  debounce_canal #(.DEB_CYCLES(DEB_CYCLES)) uUs (
    .Clk(Clk), .Rst(Rst), .rawIn(bus.Us_raw), .filtOut(usFilt)
  );

  debounce_canal #(.DEB_CYCLES(DEB_CYCLES)) uBs (
    .Clk(Clk), .Rst(Rst), .rawIn(bus.Bs_raw), .filtOut(bsFilt)
  );

  debounce_canal #(.DEB_CYCLES(DEB_CYCLES)) uVs (
    .Clk(Clk), .Rst(Rst), .rawIn(bus.Vs_raw), .filtOut(vsFilt)
  );

  debounce_canal #(.DEB_CYCLES(DEB_CYCLES)) uAdub (
    .Clk(Clk), .Rst(Rst), .rawIn(bus.Adub_raw), .filtOut(adubFilt)
  );

  // Judged on the unmasked filtered levels; the masked outputs would always
  // look consistent during a fault and clear it prematurely.
  assign inconsistent = vsFilt & ~bsFilt;

  // Strobe lands on the cycle after filtered Us rises; falling edges are
  // ignored because usFilt is 0 then.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      usDly  <= 1'b0;
      usSobe <= 1'b0;
    end else begin
      usDly  <= usFilt;
      usSobe <= usFilt & ~usDly;
    end
  end

  // Fault FSM state, suspicion counter and the registered fault flag.
  // The flag is loaded from nextState so it tracks the state register
  // cycle-for-cycle without a decode path on the output.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= OK;
      falhaCnt <= '0;
      falhaReg <= 1'b0;
    end else begin
      state    <= nextState;
      falhaCnt <= falhaCntNext;
      falhaReg <= (nextState == FALHA);
    end
  end

  // Next-state logic. The suspicion counter only advances while the
  // inconsistency persists and enters FALHA on the cycle it would reach
  // FALHA_CYCLES. Leaving FALHA needs the clear and a consistent reading
  // together, so a clear pressed during the fault is ignored.
  always_comb begin
    nextState    = state;
    falhaCntNext = falhaCnt;
    case (state)
      OK: begin
        falhaCntNext = '0;
        if (inconsistent) nextState = SUSPEITA;
      end
      SUSPEITA: begin
        if (!inconsistent) begin
          nextState    = OK;
          falhaCntNext = '0;
        end else if (falhaCnt == FCNT_LAST) begin
          nextState    = FALHA;
          falhaCntNext = '0;
        end else begin
          falhaCntNext = falhaCnt + FCNT_ONE;
        end
      end
      FALHA: begin
        falhaCntNext = '0;
        if (bus.Clr_Falha && !inconsistent) nextState = OK;
      end
      default: begin
        nextState    = OK;
        falhaCntNext = '0;
      end
    endcase
  end

  assign bus.Us      = usFilt;
  assign bus.Bs      = bsFilt & ~falhaReg;
  assign bus.Vs      = vsFilt & ~falhaReg;
  assign bus.Adub    = adubFilt;
  assign bus.Us_sobe = usSobe;
  assign bus.Falha   = falhaReg;

endmodule

// File: tb/tb_filtro_sensores.sv
// Directed testbench for filtro_sensores with DEB_CYCLES=4, FALHA_CYCLES=8.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so "after N ticks" means after the Nth rising edge.
module tb_filtro_sensores;

  logic Clk;
  logic Rst;
  int   tests;
  int   fails;

  filtro_sensores_if bus ();

  filtro_sensores #(.DEB_CYCLES(4), .FALHA_CYCLES(8)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  // 10-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic us, input logic bs, input logic vs,
                               input logic adub, input logic clr);
    bus.Us_raw    = us;
    bus.Bs_raw    = bs;
    bus.Vs_raw    = vs;
    bus.Adub_raw  = adub;
    bus.Clr_Falha = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Rst   = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);

    // Reset state.
    checkOutput("rst_Us", 8'(bus.Us), 8'd0);
    checkOutput("rst_Bs", 8'(bus.Bs), 8'd0);
    checkOutput("rst_Vs", 8'(bus.Vs), 8'd0);
    checkOutput("rst_Adub", 8'(bus.Adub), 8'd0);
    checkOutput("rst_Us_sobe", 8'(bus.Us_sobe), 8'd0);
    checkOutput("rst_Falha", 8'(bus.Falha), 8'd0);
    Rst = 1'b1;
    tick(2);

    // Us rising: output after 6 edges, strobe on the 7th only.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(5);
    checkOutput("us_rise_t5", 8'(bus.Us), 8'd0);
    tick(1);
    checkOutput("us_rise_t6", 8'(bus.Us), 8'd1);
    checkOutput("us_sobe_t6", 8'(bus.Us_sobe), 8'd0);
    tick(1);
    checkOutput("us_sobe_t7", 8'(bus.Us_sobe), 8'd1);
    tick(1);
    checkOutput("us_sobe_t8", 8'(bus.Us_sobe), 8'd0);
    checkOutput("us_hold_t8", 8'(bus.Us), 8'd1);

    // Us falling: no strobe.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(6);
    checkOutput("us_fall_t6", 8'(bus.Us), 8'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("us_fall_nosobe", 8'(bus.Us_sobe), 8'd0);
      tick(1);
    end

    // Bs glitch of 3 cycles: counter climbs to 3 then returns to 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("bs_glitch_cnt3", 8'(dut.uBs.cnt), 8'd3);
    checkOutput("bs_glitch_out5", 8'(bus.Bs), 8'd0);
    tick(1);
    checkOutput("bs_glitch_cnt0", 8'(dut.uBs.cnt), 8'd0);
    tick(4);
    checkOutput("bs_glitch_out10", 8'(bus.Bs), 8'd0);

    // Vs high with Bs low, Adub rising simultaneously.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(5);
    checkOutput("vs_t5", 8'(bus.Vs), 8'd0);
    tick(1);
    checkOutput("vs_t6", 8'(bus.Vs), 8'd1);
    checkOutput("adub_t6", 8'(bus.Adub), 8'd1);
    checkOutput("falha_t6", 8'(bus.Falha), 8'd0);
    tick(8);
    checkOutput("falha_t14", 8'(bus.Falha), 8'd0);
    checkOutput("vs_t14", 8'(bus.Vs), 8'd1);
    tick(1);
    checkOutput("falha_t15", 8'(bus.Falha), 8'd1);
    checkOutput("vs_masked", 8'(bus.Vs), 8'd0);
    checkOutput("bs_masked", 8'(bus.Bs), 8'd0);
    checkOutput("adub_unmasked", 8'(bus.Adub), 8'd1);

    // Clear while still inconsistent is ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(2);
    checkOutput("clr_inconsistent", 8'(bus.Falha), 8'd1);

    // Bs filtered high, output still masked until the clear.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(6);
    checkOutput("bs_masked_pre_clr", 8'(bus.Bs), 8'd0);
    checkOutput("falha_pre_clr", 8'(bus.Falha), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkOutput("falha_cleared", 8'(bus.Falha), 8'd0);
    checkOutput("bs_after_clr", 8'(bus.Bs), 8'd1);
    checkOutput("vs_after_clr", 8'(bus.Vs), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(2);
    checkOutput("falha_stays_clear", 8'(bus.Falha), 8'd0);

    // Reset mid-debounce of Us: everything clears immediately.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(3);
    #3 Rst = 1'b0;
    #1;
    checkOutput("midrst_Bs", 8'(bus.Bs), 8'd0);
    checkOutput("midrst_Vs", 8'(bus.Vs), 8'd0);
    checkOutput("midrst_Adub", 8'(bus.Adub), 8'd0);
    checkOutput("midrst_UsCnt", 8'(dut.uUs.cnt), 8'd0);
    tick(1);
    Rst = 1'b1;

    // Inputs already high reach outputs 6 edges after release.
    tick(5);
    checkOutput("rel_Us_t5", 8'(bus.Us), 8'd0);
    tick(1);
    checkOutput("rel_Us_t6", 8'(bus.Us), 8'd1);
    checkOutput("rel_Bs_t6", 8'(bus.Bs), 8'd1);
    checkOutput("rel_Vs_t6", 8'(bus.Vs), 8'd1);
    tick(1);
    checkOutput("rel_sobe_t7", 8'(bus.Us_sobe), 8'd1);

    // Drive back into FALHA, then reset inside it.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(14);
    checkOutput("refault_t14", 8'(bus.Falha), 8'd0);
    tick(1);
    checkOutput("refault_t15", 8'(bus.Falha), 8'd1);
    #3 Rst = 1'b0;
    #1;
    checkOutput("faultrst_Falha", 8'(bus.Falha), 8'd0);
    checkOutput("faultrst_Us", 8'(bus.Us), 8'd0);
    checkOutput("faultrst_Adub", 8'(bus.Adub), 8'd0);
    tick(1);
    Rst = 1'b1;
    tick(6);
    checkOutput("postrst_Vs", 8'(bus.Vs), 8'd1);
    checkOutput("postrst_Falha", 8'(bus.Falha), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/filtro_sensores.md
FILTRO_SENSORES -- requirements
Module: filtro_sensores

Interface
REQ-001 Parameter DEB_CYCLES, default 16, SHALL be the consecutive stable cycles required before a filtered output changes (legal range 2..65535).
REQ-002 Parameter FALHA_CYCLES, default 64, SHALL be the consecutive inconsistent cycles required before the reservoir fault is declared (legal range 2..65535).
REQ-003 Clk  input  1  system clock; the block SHALL have this single clock domain.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 Us_raw, Bs_raw, Vs_raw, Adub_raw  input  1 each  raw asynchronous sensor/switch levels: soil dryness, reservoir low float, reservoir high float, fertilise request.
REQ-006 Clr_Falha  input  1  synchronous fault-clear request, level-sensitive.
REQ-007 Us, Bs, Vs, Adub  output  1 each  filtered, registered sensor levels for the irrigation controller.
REQ-008 Us_sobe  output  1  one-cycle strobe on each 0->1 transition of filtered Us.
REQ-009 Falha  output  1  reservoir sensor inconsistency fault, sticky.

Function
REQ-010 Each raw input SHALL pass through a 2-flip-flop synchronizer before any other logic.
REQ-011 Each channel SHALL hold a counter that increments while the synchronized input differs from the filtered output and clears to 0 on any cycle where they agree.
REQ-012 The filtered output SHALL toggle, and its counter SHALL clear, on the cycle the counter would reach DEB_CYCLES; latency from a stable raw change to the output change is therefore exactly 2 + DEB_CYCLES cycles.
REQ-013 A glitch shorter than DEB_CYCLES synchronized cycles SHALL produce no output change.
REQ-014 Counters SHALL saturate and never wrap; their width SHALL be the minimum that holds DEB_CYCLES or FALHA_CYCLES.
REQ-015 Us_sobe SHALL assert for exactly the one cycle after filtered Us goes 0->1; it SHALL never assert on a 1->0 transition.
REQ-016 Inconsistency is defined as filtered Vs = 1 while filtered Bs = 0.
REQ-017 The fault FSM SHALL have three states: OK, SUSPEITA and FALHA, with the following transitions.
  - OK -> SUSPEITA when inconsistent.
  - SUSPEITA -> OK when consistent; the fault counter clears.
  - SUSPEITA -> FALHA when the fault counter reaches FALHA_CYCLES.
  - FALHA -> OK only when Clr_Falha = 1 and the inputs are consistent in the same cycle.
  - Clr_Falha while still inconsistent SHALL leave the FSM in FALHA.
REQ-018 Falha SHALL be 1 exactly when the FSM is in FALHA, registered.
REQ-019 While Falha = 1, Bs and Vs SHALL both be driven 0, which forces the downstream irrigation demand off; Us and Adub are unaffected.
REQ-020 Simultaneous changes on several channels SHALL be filtered independently, with no ordering between channels.

Reset
REQ-021 Rst = 0 SHALL immediately clear all synchronizer flops, counters and outputs (Us, Bs, Vs, Adub, Us_sobe, Falha = 0) and place the FSM in OK.
REQ-022 After Rst deasserts, an input that is already 1 SHALL reach its output after 2 + DEB_CYCLES cycles, with no Us_sobe suppression.
REQ-023 Reset asserted mid-debounce or in FALHA SHALL discard all progress; no state survives reset.

Structure
REQ-024 The FSM state encoding and the default values of DEB_CYCLES and FALHA_CYCLES SHALL reside in the shared package rega_pkg.
REQ-025 The synchronizer plus debounce counter SHALL be one sub-module, debounce_canal, instantiated four times.
REQ-026 The fault FSM and the edge strobe SHALL reside in filtro_sensores itself.

Verification (DEB_CYCLES = 4, FALHA_CYCLES = 8)
REQ-027 Us_raw 0->1 held -> Us = 1 exactly 6 cycles later; Us_sobe = 1 for one cycle, on the following cycle.
REQ-028 Bs_raw pulses high for 3 cycles -> Bs stays 0 and the counter returns to 0.
REQ-029 Bs_raw = 0, Vs_raw 0->1 held -> Vs = 1 after 6 cycles; Falha = 1 after 8 further cycles plus 1 register cycle, after which Bs = Vs = 0.
REQ-030 In FALHA, Clr_Falha = 1 with the inconsistency present -> Falha stays 1; after Bs_raw = 1 is filtered, Clr_Falha = 1 -> Falha = 0 next cycle.
REQ-031 Rst pulsed low mid-debounce and in FALHA -> all outputs 0 immediately; debounce restarts from 0 after release.
